// File: rtl/uart_tx_fifo_if.sv
// Host-side handshake and status bundle for uart_tx_fifo.
// The host drives data/valid through master; the transmitter owns the rest through slave.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [7:0]                    tx_data;
  logic                          tx_valid;
  logic                          tx_ready;
  logic                          tx;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (output tx_data, tx_valid, input tx_ready, tx, busy, fifo_count);
  modport slave  (input tx_data, tx_valid, output tx_ready, tx, busy, fifo_count);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO, LSB first, DIV = CLK_FREQ/BAUD cycles per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  logic       w_full, w_push, w_pop, w_baud_done;
  logic [7:0] w_head;

  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_push      = bus.tx_valid && !w_full;
  assign w_baud_done = (r_baud == CW'(DIV - 1));
  // A new frame starts straight out of IDLE or at the last cycle of STOP, so frames abut.
  assign w_pop       = (r_count != '0) &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));
  assign w_head      = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wptr] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_pop) begin
      r_state <= S_START;
      r_baud  <= '0;
      r_shift <= w_head;
      r_tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= ^w_head;
`endif
    end else begin
      case (r_state)
        S_IDLE: r_baud <= '0;
        S_START: begin
          if (w_baud_done) begin
            r_state <= S_DATA;
            r_baud  <= '0;
            r_tx    <= r_shift[0];
          end else r_baud <= r_baud + 1'b1;
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            r_bit  <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_par;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else r_baud <= r_baud + 1'b1;
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_done) begin
            r_state <= S_STOP;
            r_baud  <= '0;
            r_tx    <= 1'b1;
          end else r_baud <= r_baud + 1'b1;
        end
`endif
        S_STOP: begin
          if (w_baud_done) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
          end else r_baud <= r_baud + 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx         = r_tx;
  assign bus.tx_ready   = !w_full;
  assign bus.busy       = (r_state != S_IDLE) || (r_count != '0);
  assign bus.fifo_count = r_count;
endmodule
